spi_mem_ctrl: RTL and testbench



---
 rtl/spi_mem_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - single-bit SPI memory controller serving flash and PSRAM requests
// Optional macro SPI_MEM_FAST_READ_EN: flash reads use 8'h0B plus 8 dummy bits.
module spi_mem_ctrl #(
  parameter logic [7:0] FLASH_CMD_READ = 8'h03,
  parameter logic [7:0] RAM_CMD_READ   = 8'h03,
  parameter logic [7:0] RAM_CMD_WRITE  = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] spi_addr,
  input  logic [31:0] spi_wdata,
  input  logic        spi_we,
  input  logic        spi_mem_select,
  input  logic        spi_valid,
  output logic        spi_ready,
  output logic [31:0] spi_rdata,
  output logic        flash_cs_n,
  output logic        ram_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
`ifdef SPI_MEM_FAST_READ_EN
    ST_DUMMY,
`endif
    ST_DATA,
    ST_DONE,
    ST_RECOVER
  } state_t;

`ifdef SPI_MEM_FAST_READ_EN
  localparam logic [7:0] FAST_READ_CMD = 8'h0B;
`endif

  state_t      state_q, state_d, next_bit_state;
  logic        phase_q, phase_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  last_bit;
  logic        last;
  logic [62:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        we_q, we_d;
  logic        sel_q, sel_d;
  logic        flash_cs_n_q, flash_cs_n_d;
  logic        ram_cs_n_q, ram_cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  opcode;
  logic        mosi_zero;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    if (spi_mem_select) begin
      opcode = spi_we ? RAM_CMD_WRITE : RAM_CMD_READ;
    end else begin
`ifdef SPI_MEM_FAST_READ_EN
      opcode = FAST_READ_CMD;
`else
      opcode = FLASH_CMD_READ;
`endif
    end
  end

  always_comb begin
    last_bit       = 5'd0;
    next_bit_state = ST_IDLE;
    case (state_q)
      ST_CMD: begin
        last_bit       = 5'd7;
        next_bit_state = ST_ADDR;
      end
      ST_ADDR: begin
        last_bit       = 5'd23;
`ifdef SPI_MEM_FAST_READ_EN
        next_bit_state = sel_q ? ST_DATA : ST_DUMMY;
`else
        next_bit_state = ST_DATA;
`endif
      end
`ifdef SPI_MEM_FAST_READ_EN
      ST_DUMMY: begin
        last_bit       = 5'd7;
        next_bit_state = ST_DATA;
      end
`endif
      ST_DATA: begin
        last_bit       = 5'd31;
        next_bit_state = ST_DONE;
      end
      default: ;
    endcase
  end

  assign last = (bit_cnt_q == last_bit);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    we_d         = we_q;
    sel_d        = sel_q;
    flash_cs_n_d = flash_cs_n_q;
    ram_cs_n_d   = ram_cs_n_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    mosi_zero    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (spi_valid) begin
          we_d  = spi_we;
          sel_d = spi_mem_select;
          if (!spi_mem_select && spi_we) begin
            // Flash is read-only here: complete immediately without touching the bus.
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            state_d      = ST_CMD;
            tx_d         = {opcode[6:0], spi_addr, swap_bytes(spi_wdata)};
            mosi_d       = opcode[7];
            flash_cs_n_d = spi_mem_select;
            ram_cs_n_d   = !spi_mem_select;
            sck_d        = 1'b0;
            phase_d      = 1'b0;
            bit_cnt_d    = 5'd0;
          end
        end
      end
      ST_DONE:    state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default: begin
        if (!phase_q) begin
          sck_d   = 1'b1;
          phase_d = 1'b1;
          rx_d    = {rx_q[30:0], spi_miso};
        end else begin
          sck_d   = 1'b0;
          phase_d = 1'b0;
          if (last) begin
            bit_cnt_d = 5'd0;
            state_d   = next_bit_state;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (last && state_q == ST_DATA) begin
            flash_cs_n_d = 1'b1;
            ram_cs_n_d   = 1'b1;
            ready_d      = 1'b1;
            mosi_d       = 1'b0;
            if (!we_q) rdata_d = swap_bytes(rx_q);
          end else begin
`ifdef SPI_MEM_FAST_READ_EN
            // Dummy bits do not consume payload, so the data bits stay queued.
            if (state_q != ST_DUMMY) tx_d = {tx_q[61:0], 1'b0};
            mosi_zero = (state_d == ST_DUMMY) || (state_d == ST_DATA && !we_q);
`else
            tx_d      = {tx_q[61:0], 1'b0};
            mosi_zero = (state_d == ST_DATA && !we_q);
`endif
            mosi_d = mosi_zero ? 1'b0 : tx_q[62];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= 5'd0;
      tx_q         <= '0;
      rx_q         <= '0;
      we_q         <= 1'b0;
      sel_q        <= 1'b0;
      flash_cs_n_q <= 1'b1;
      ram_cs_n_q   <= 1'b1;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      flash_cs_n_q <= flash_cs_n_d;
      ram_cs_n_q   <= ram_cs_n_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
    end
  end

  assign spi_ready  = ready_q;
  assign spi_rdata  = rdata_q;
  assign flash_cs_n = flash_cs_n_q;
  assign ram_cs_n   = ram_cs_n_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - directed scoreboard bench for spi_mem_ctrl
// Honours SPI_MEM_FAST_READ_EN when the design is built with it.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] spi_addr = '0;
  logic [31:0] spi_wdata = '0;
  logic        spi_we = 1'b0;
  logic        spi_mem_select = 1'b0;
  logic        spi_valid = 1'b0;
  logic        spi_ready;
  logic [31:0] spi_rdata;
  logic        flash_cs_n;
  logic        ram_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_mem_ctrl dut (
    .clk(clk), .rst(rst), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_we(spi_we), .spi_mem_select(spi_mem_select), .spi_valid(spi_valid),
    .spi_ready(spi_ready), .spi_rdata(spi_rdata), .flash_cs_n(flash_cs_n),
    .ram_cs_n(ram_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

`ifdef SPI_MEM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int          RD_LAT     = FAST ? 145 : 129;
  localparam logic [7:0]  FLASH_OP   = FAST ? 8'h0B : 8'h03;
  localparam logic [31:0] MODEL_WORD = 32'h78563412;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  int flash_low_cnt = 0, ram_low_cnt = 0, sck_hi_cnt = 0, ready_cnt = 0, miso_idx = 0;
  logic mosi_bits[$];
  int fl0, rm0, sck0, bit0, rdy0;

  function automatic logic model_bit(input int idx, input logic is_flash);
    logic [31:0] w;
    int hdr, d;
    w   = MODEL_WORD;
    hdr = (is_flash && FAST) ? 40 : 32;
    d   = idx - hdr;
    if (d >= 0 && d < 32) return w[31-d];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!flash_cs_n) flash_low_cnt <= flash_low_cnt + 1;
    if (!ram_cs_n)   ram_low_cnt   <= ram_low_cnt + 1;
    if (spi_sck)     sck_hi_cnt    <= sck_hi_cnt + 1;
    if (spi_ready)   ready_cnt     <= ready_cnt + 1;
    if (flash_cs_n && ram_cs_n) begin
      miso_idx <= 0;
      spi_miso <= 1'b0;
    end else if (!spi_sck) begin
      mosi_bits.push_back(spi_mosi);
      miso_idx <= miso_idx + 1;
      spi_miso <= model_bit(miso_idx, !flash_cs_n);
    end
  end

  function automatic logic [63:0] get_bits(input int s, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[62:0], mosi_bits[s+i]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [23:0] a, input logic [31:0] wd, input logic we,
                           input logic sel, input logic [31:0] exp_rd, input int exp_lat,
                           input bit push);
    exp_t e;
    if (push) begin
      e.rdata = exp_rd;
      e.lat   = exp_lat;
      sb.push_back(e);
    end
    fl0  = flash_low_cnt;
    rm0  = ram_low_cnt;
    sck0 = sck_hi_cnt;
    bit0 = mosi_bits.size();
    spi_addr       = a;
    spi_wdata      = wd;
    spi_we         = we;
    spi_mem_select = sel;
    spi_valid      = 1'b1;
  endtask

  task automatic finish_req(input string tag, input int k0, input bit keep);
    int   k;
    exp_t e;
    k = k0;
    while (!spi_ready && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, k, e.lat);
    check({tag, "_rdata"}, spi_rdata, e.rdata);
    if (!keep) begin
      spi_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int j;
    logic [7:0] op;
    op = FLASH_OP;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_flash_cs_n", flash_cs_n, 1'b1);
    check("rst_ram_cs_n", ram_cs_n, 1'b1);
    check("rst_sck", spi_sck, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_ready", spi_ready, 1'b0);
    check("rst_rdata", spi_rdata, 32'h0);

    // Flash read
    start_req(24'h012345, 32'h0, 1'b0, 1'b0, 32'h12345678, RD_LAT, 1'b1);
    @(posedge clk); #1;
    check("t1_first_cs", flash_cs_n, 1'b0);
    check("t1_first_sck", spi_sck, 1'b0);
    check("t1_first_mosi", spi_mosi, op[7]);
    finish_req("t1", 1, 1'b0);
    check("t1_flash_low", flash_low_cnt - fl0, RD_LAT - 1);
    check("t1_ram_low", ram_low_cnt - rm0, 0);
    check("t1_bits", mosi_bits.size() - bit0, (RD_LAT - 1) / 2);
    check("t1_mosi_hdr", get_bits(bit0, 32), {FLASH_OP, 24'h012345});
    check("t1_mosi_tail", get_bits(bit0 + 32, 32), 64'h0);

    // PSRAM write
    start_req(24'h000010, 32'hDEADBEEF, 1'b1, 1'b1, 32'h12345678, 129, 1'b1);
    finish_req("t2", 0, 1'b0);
    check("t2_mosi_hdr", get_bits(bit0, 32), 32'h02000010);
    check("t2_mosi_data", get_bits(bit0 + 32, 32), 32'hEFBEADDE);
    check("t2_ram_low", ram_low_cnt - rm0, 128);
    check("t2_flash_low", flash_low_cnt - fl0, 0);

    // Flash write: no bus activity
    start_req(24'h000100, 32'h11111111, 1'b1, 1'b0, 32'h12345678, 1, 1'b1);
    finish_req("t3", 0, 1'b0);
    check("t3_flash_low", flash_low_cnt - fl0, 0);
    check("t3_ram_low", ram_low_cnt - rm0, 0);
    check("t3_sck", sck_hi_cnt - sck0, 0);

    // PSRAM read with valid held across ready
    start_req(24'h000020, 32'h0, 1'b0, 1'b1, 32'h12345678, 129, 1'b1);
    finish_req("t4a", 0, 1'b1);
    j = 0;
    while (flash_cs_n && ram_cs_n && j < 10) begin
      @(posedge clk); #1;
      j++;
    end
    check("t4_restart_gap", j, 3);
    start_req(24'h000020, 32'h0, 1'b0, 1'b1, 32'h12345678, 129, 1'b1);
    finish_req("t4b", 1, 1'b0);

    // Reset in the middle of a flash read
    start_req(24'h000040, 32'h0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("t5_cs_before", flash_cs_n, 1'b0);
    rst = 1'b1;
    spi_valid = 1'b0;
    #1;
    check("t5_flash_cs_n", flash_cs_n, 1'b1);
    check("t5_ram_cs_n", ram_cs_n, 1'b1);
    check("t5_sck", spi_sck, 1'b0);
    check("t5_ready", spi_ready, 1'b0);
    check("t5_rdata", spi_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy0 = ready_cnt;
    repeat (150) @(posedge clk);
    #1;
    check("t5_no_ready", ready_cnt - rdy0, 0);
    check("t5_rdata_after", spi_rdata, 32'h0);

    // Read after reset completes normally
    start_req(24'h0000AA, 32'h0, 1'b0, 1'b0, 32'h12345678, RD_LAT, 1'b1);
    finish_req("t6", 0, 1'b0);
    check("t6_mosi_hdr", get_bits(bit0, 32), {FLASH_OP, 24'h0000AA});
    check("t6_flash_low", flash_low_cnt - fl0, RD_LAT - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
